mem_access_stage: RTL and testbench

//  MEM stage of the LEGv8 pipeline; sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_stage_pkg.sv | 19 +
 rtl/mem_timeout_counter.sv | 33 +++
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the LEGv8 MEM stage: widths, FSM state encoding and
// the doubleword alignment helper.
package mem_access_stage_pkg;

    localparam int DATA_W = 64;

    localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-3){1'b1}}, 3'b000};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return ((addr & ~ALIGN_MASK) != {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory ack; expired is high once the
// count reaches TIMEOUT-1, and the counter saturates there.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter, cleared whenever no request is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: runs loads/stores over a req/ack data-memory handshake,
// stalls upstream while an access is outstanding and faults bad accesses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] aluResult_in,
    input  logic [DATA_W-1:0] storeData_in,
    input  logic [4:0]        writeReg_in,
    input  logic              regWrite_in,
    input  logic              memToReg_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] memAddress_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [4:0]        writeReg_out,
    output logic              regWrite_out,
    output logic              memToReg_out,
    output logic              mem_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    state_t            state_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] rdata_r;
    logic [4:0]        wreg_r;
    logic              regwrite_r;
    logic              memtoreg_r;
    logic              fault_r;
    logic              memop_s;
    logic              misal_s;
    logic              expired_s;

    assign memop_s = valid_in & (memRead_in | memWrite_in);
    assign misal_s = is_misaligned(aluResult_in);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .clear   (state_r != S_REQ),
        .enable  ((state_r == S_REQ) && !dmem_ack),
        .expired (expired_s)
    );

    // Access FSM with registered bus signals, latches and fault pulse
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {DATA_W{1'b0}};
            dmem_wdata <= {DATA_W{1'b0}};
            addr_r     <= {DATA_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            wreg_r     <= 5'd0;
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    fault_r <= 1'b0;
                    if (memop_s) begin
                        addr_r     <= aluResult_in;
                        rdata_r    <= {DATA_W{1'b0}};
                        wreg_r     <= writeReg_in;
                        regwrite_r <= regWrite_in;
                        memtoreg_r <= memToReg_in;
                        if (misal_s) begin
                            fault_r <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= memWrite_in;
                            dmem_addr  <= aluResult_in & ALIGN_MASK;
                            dmem_wdata <= storeData_in;
                            state_r    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the timeout cycle still completes normally
                    if (dmem_ack) begin
                        rdata_r  <= dmem_we ? {DATA_W{1'b0}} : dmem_rdata;
                        dmem_req <= 1'b0;
                        state_r  <= S_DONE;
                    end else if (expired_s) begin
                        dmem_req <= 1'b0;
                        fault_r  <= 1'b1;
                        state_r  <= S_DONE;
                    end
                end
                S_DONE: begin
                    fault_r <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    dmem_req <= 1'b0;
                    fault_r  <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_fault = fault_r;

    // MEM/WB-facing outputs: passthrough, bubble or latched completion
    always_comb begin
        stall_out      = 1'b1;
        memAddress_out = addr_r;
        memData_out    = {DATA_W{1'b0}};
        writeReg_out   = wreg_r;
        regWrite_out   = 1'b0;
        memToReg_out   = 1'b0;
        case (state_r)
            S_IDLE: begin
                memAddress_out = aluResult_in;
                writeReg_out   = writeReg_in;
                if (memop_s) begin
                    stall_out = 1'b1;
                end else begin
                    stall_out    = 1'b0;
                    regWrite_out = regWrite_in & valid_in;
                    memToReg_out = memToReg_in;
                end
            end
            S_REQ: begin
                stall_out = 1'b1;
            end
            S_DONE: begin
                stall_out = 1'b0;
                if (fault_r) begin
                    regWrite_out = 1'b0;
                    memToReg_out = 1'b0;
                end else begin
                    regWrite_out = regwrite_r;
                    memToReg_out = memtoreg_r;
                    memData_out  = rdata_r;
                end
            end
            default: begin
                stall_out = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, loads, stores, misalignment,
// bus timeout and reset during an outstanding request.
module tb_mem_access_stage;

    logic        CLOCK;
    logic        RESET_N;
    logic        valid_in;
    logic [63:0] aluResult_in;
    logic [63:0] storeData_in;
    logic [4:0]  writeReg_in;
    logic        regWrite_in;
    logic        memToReg_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic        stall_out;
    logic [63:0] memAddress_out;
    logic [63:0] memData_out;
    logic [4:0]  writeReg_out;
    logic        regWrite_out;
    logic        memToReg_out;
    logic        mem_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          stalls;
    int          req_cycles;
    logic        seen_we;
    logic [63:0] seen_addr;
    logic [63:0] seen_wdata;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .valid_in       (valid_in),
        .aluResult_in   (aluResult_in),
        .storeData_in   (storeData_in),
        .writeReg_in    (writeReg_in),
        .regWrite_in    (regWrite_in),
        .memToReg_in    (memToReg_in),
        .memRead_in     (memRead_in),
        .memWrite_in    (memWrite_in),
        .stall_out      (stall_out),
        .memAddress_out (memAddress_out),
        .memData_out    (memData_out),
        .writeReg_out   (writeReg_out),
        .regWrite_out   (regWrite_out),
        .memToReg_out   (memToReg_out),
        .mem_fault      (mem_fault),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                             input logic [4:0] wr, input logic rw, input logic m2r,
                             input logic rd, input logic wt);
        valid_in     = v;
        aluResult_in = alu;
        storeData_in = sd;
        writeReg_in  = wr;
        regWrite_in  = rw;
        memToReg_in  = m2r;
        memRead_in   = rd;
        memWrite_in  = wt;
    endtask

    // Runs one memory op already presented on the inputs (called #1 after an edge).
    // Returns at the negedge of the first non-stalled cycle (DONE).
    task automatic run_mem(input int ack_after, input logic [63:0] rdata);
        int c;
        stalls     = 0;
        req_cycles = 0;
        for (c = 0; c < 40; c++) begin
            dmem_ack   = (ack_after >= 0) && (c == 1 + ack_after);
            dmem_rdata = rdata;
            @(negedge CLOCK);
            if (!stall_out) break;
            stalls++;
            if (dmem_req) begin
                req_cycles++;
                seen_we    = dmem_we;
                seen_addr  = dmem_addr;
                seen_wdata = dmem_wdata;
            end
            next_cycle();
        end
        dmem_ack = 1'b0;
        check_val("mem_op_completes", {63'd0, (c < 40)}, 64'd1);
    endtask

    initial begin
        RESET_N    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
        seen_we    = 1'b0;
        seen_addr  = 64'd0;
        seen_wdata = 64'd0;
        set_instr(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge CLOCK);
        check_val("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check_val("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        check_val("rst_mem_fault", {63'd0, mem_fault}, 64'd0);
        check_val("rst_dmem_addr", dmem_addr, 64'd0);
        check_val("rst_dmem_wdata", dmem_wdata, 64'd0);
        check_val("rst_stall", {63'd0, stall_out}, 64'd0);
        RESET_N = 1'b1;
        next_cycle();

        // 1: ADD X5, zero-latency passthrough; a stray ack in IDLE is ignored
        set_instr(1'b1, 64'h40, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        @(negedge CLOCK);
        check_val("add_stall", {63'd0, stall_out}, 64'd0);
        check_val("add_regwrite", {63'd0, regWrite_out}, 64'd1);
        check_val("add_addr", memAddress_out, 64'h40);
        check_val("add_wreg", {59'd0, writeReg_out}, 64'd5);
        check_val("add_memdata", memData_out, 64'd0);
        check_val("add_no_req", {63'd0, dmem_req}, 64'd0);
        next_cycle();
        dmem_ack = 1'b0;
        check_val("add_no_req_after", {63'd0, dmem_req}, 64'd0);
        set_instr(1'b0, 64'h48, 64'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK);
        check_val("invalid_regwrite", {63'd0, regWrite_out}, 64'd0);
        next_cycle();

        // 2: LDUR X3, [0x100], ack two cycles after req
        set_instr(1'b1, 64'h100, 64'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge CLOCK);
        check_val("ld_issue_bubble", {63'd0, regWrite_out}, 64'd0);
        check_val("ld_issue_memtoreg", {63'd0, memToReg_out}, 64'd0);
        next_cycle();
        @(negedge CLOCK);
        check_val("ld_req_bubble", {63'd0, regWrite_out}, 64'd0);
        // Already one cycle into REQ: two more cycles then ack
        stalls = 0;
        next_cycle();
        dmem_ack = 1'b0;
        @(negedge CLOCK);
        check_val("ld_wait_stall", {63'd0, stall_out}, 64'd1);
        next_cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        @(negedge CLOCK);
        check_val("ld_ack_stall", {63'd0, stall_out}, 64'd1);
        check_val("ld_we", {63'd0, dmem_we}, 64'd0);
        check_val("ld_dmem_addr", dmem_addr, 64'h100);
        next_cycle();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        @(negedge CLOCK);
        check_val("ld_done_stall", {63'd0, stall_out}, 64'd0);
        check_val("ld_memdata", memData_out, 64'hDEADBEEF);
        check_val("ld_wreg", {59'd0, writeReg_out}, 64'd3);
        check_val("ld_regwrite", {63'd0, regWrite_out}, 64'd1);
        check_val("ld_memtoreg", {63'd0, memToReg_out}, 64'd1);
        check_val("ld_req_dropped", {63'd0, dmem_req}, 64'd0);
        check_val("ld_no_fault", {63'd0, mem_fault}, 64'd0);
        next_cycle();

        // 2b: same load via the counting helper: issue + 2 wait + ack = 4 stalls
        set_instr(1'b1, 64'h100, 64'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        run_mem(2, 64'hDEADBEEF);
        check_val("ld_stall_cycles", stalls, 64'd4);
        check_val("ld_req_cycles", req_cycles, 64'd3);
        check_val("ld2_memdata", memData_out, 64'hDEADBEEF);
        next_cycle();

        // 3: STUR [0x208] <- 0x55, ack one cycle after req
        set_instr(1'b1, 64'h208, 64'h55, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        run_mem(1, 64'hFFFF_FFFF);
        check_val("st_stall_cycles", stalls, 64'd3);
        check_val("st_we", {63'd0, seen_we}, 64'd1);
        check_val("st_dmem_addr", seen_addr, 64'h208);
        check_val("st_dmem_wdata", seen_wdata, 64'h55);
        check_val("st_regwrite", {63'd0, regWrite_out}, 64'd0);
        check_val("st_memdata", memData_out, 64'd0);
        check_val("st_no_fault", {63'd0, mem_fault}, 64'd0);
        check_val("st_addr_out", memAddress_out, 64'h208);
        next_cycle();

        // 4: misaligned LDUR [0x103]: one stall cycle, fault, no request
        set_instr(1'b1, 64'h103, 64'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        run_mem(-1, 64'h0);
        check_val("mis_stall_cycles", stalls, 64'd1);
        check_val("mis_no_req", req_cycles, 64'd0);
        check_val("mis_fault", {63'd0, mem_fault}, 64'd1);
        check_val("mis_regwrite", {63'd0, regWrite_out}, 64'd0);
        check_val("mis_addr_out", memAddress_out, 64'h103);
        next_cycle();
        set_instr(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK);
        check_val("mis_fault_pulse", {63'd0, mem_fault}, 64'd0);
        check_val("mis_idle_stall", {63'd0, stall_out}, 64'd0);
        next_cycle();

        // 5: LDUR [0x80] with no ack: 16 request cycles then timeout fault
        set_instr(1'b1, 64'h80, 64'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        run_mem(-1, 64'h0);
        check_val("to_req_cycles", req_cycles, 64'd16);
        check_val("to_stall_cycles", stalls, 64'd17);
        check_val("to_fault", {63'd0, mem_fault}, 64'd1);
        check_val("to_regwrite", {63'd0, regWrite_out}, 64'd0);
        check_val("to_req_dropped", {63'd0, dmem_req}, 64'd0);
        next_cycle();

        // 5b: ack on the 16th request cycle wins over the timeout
        set_instr(1'b1, 64'h80, 64'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        run_mem(15, 64'h1234_5678_9ABC_DEF0);
        check_val("late_req_cycles", req_cycles, 64'd16);
        check_val("late_no_fault", {63'd0, mem_fault}, 64'd0);
        check_val("late_regwrite", {63'd0, regWrite_out}, 64'd1);
        check_val("late_memdata", memData_out, 64'h1234_5678_9ABC_DEF0);
        next_cycle();

        // 6: reset while a request is outstanding, then a stray ack
        set_instr(1'b1, 64'h180, 64'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        @(negedge CLOCK);
        check_val("rst6_req_up", {63'd0, dmem_req}, 64'd1);
        RESET_N = 1'b0;
        set_instr(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("rst6_req_drop", {63'd0, dmem_req}, 64'd0);
        check_val("rst6_stall", {63'd0, stall_out}, 64'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        next_cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD0_BAD0;
        @(negedge CLOCK);
        check_val("rst6_stray_req", {63'd0, dmem_req}, 64'd0);
        check_val("rst6_stray_stall", {63'd0, stall_out}, 64'd0);
        next_cycle();
        dmem_ack = 1'b0;
        set_instr(1'b1, 64'h60, 64'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK);
        check_val("rst6_idle_pass", {63'd0, stall_out}, 64'd0);
        check_val("rst6_memdata", memData_out, 64'd0);
        check_val("rst6_no_fault", {63'd0, mem_fault}, 64'd0);
        check_val("rst6_addr", memAddress_out, 64'h60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
